// File: rtl/pc_gen_if.sv
// Fetch-PC bundle between the IF-stage PC generator and its surroundings
// (hazard unit, EX branch resolution, CSR trap logic).
interface pc_gen_if #(
  parameter int unsigned XLEN = 32
);
  logic            stall_i;
  logic            br_redirect_i;
  logic [XLEN-1:0] br_target_i;
  logic            trap_redirect_i;
  logic [XLEN-1:0] trap_target_i;
  logic [XLEN-1:0] pc_o;
  logic [XLEN-1:0] pc_plus4_o;
  logic            pending_o;
  logic            misalign_o;
  logic [XLEN-1:0] misalign_addr_o;

  // master: pipeline side driving redirects/stall; slave: the PC generator.
  modport master (
    output stall_i, br_redirect_i, br_target_i, trap_redirect_i, trap_target_i,
    input  pc_o, pc_plus4_o, pending_o, misalign_o, misalign_addr_o
  );

  modport slave (
    input  stall_i, br_redirect_i, br_target_i, trap_redirect_i, trap_target_i,
    output pc_o, pc_plus4_o, pending_o, misalign_o, misalign_addr_o
  );
endinterface

// File: rtl/pc_gen_unit.sv
// IF-stage program-counter generator: +4 sequencing, stall hold, branch/trap redirects.
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned branch target traps to TRAP_VECTOR).
module pc_gen_unit #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h8000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h8000_0100
) (
    input logic     clk,
    input logic     rst,
    pc_gen_if.slave bus
);

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    logic [XLEN-1:0] trap_tgt;
    logic            apply;
    logic [XLEN-1:0] apply_tgt;
`ifdef PC_MISALIGN_TRAP_EN
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;
`endif

    assign trap_tgt = {bus.trap_target_i[XLEN-1:2], 2'b00};

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        tgt_d     = tgt_q;
        apply     = 1'b0;
        apply_tgt = '0;
`ifdef PC_MISALIGN_TRAP_EN
        misalign_d      = 1'b0;
        misalign_addr_d = misalign_addr_q;
`endif
        if (bus.trap_redirect_i) begin
            pc_d    = trap_tgt;
            tgt_d   = '0;
            state_d = RUN;
        end else if (bus.stall_i) begin
            if (bus.br_redirect_i) begin
                tgt_d   = bus.br_target_i;
                state_d = HOLD;
            end
        end else if (state_q == HOLD) begin
            // A branch resolved in the release cycle is younger than the latched one.
            apply     = 1'b1;
            apply_tgt = bus.br_redirect_i ? bus.br_target_i : tgt_q;
            state_d   = RUN;
        end else if (bus.br_redirect_i) begin
            apply     = 1'b1;
            apply_tgt = bus.br_target_i;
        end else begin
            pc_d = pc_q + XLEN'(4);
        end

        if (apply) begin
`ifdef PC_MISALIGN_TRAP_EN
            if (apply_tgt[1:0] != 2'b00) begin
                pc_d            = TRAP_VECTOR;
                misalign_d      = 1'b1;
                misalign_addr_d = apply_tgt;
            end else begin
                pc_d = apply_tgt;
            end
`else
            pc_d = {apply_tgt[XLEN-1:2], 2'b00};
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_VECTOR;
            tgt_q   <= '0;
`ifdef PC_MISALIGN_TRAP_EN
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
`ifdef PC_MISALIGN_TRAP_EN
            misalign_q      <= misalign_d;
            misalign_addr_q <= misalign_addr_d;
`endif
        end
    end

    assign bus.pc_o       = pc_q;
    assign bus.pc_plus4_o = pc_q + XLEN'(4);
    assign bus.pending_o  = (state_q == HOLD);

`ifdef PC_MISALIGN_TRAP_EN
    assign bus.misalign_o      = misalign_q;
    assign bus.misalign_addr_o = misalign_addr_q;

    logic unused_bits;
    assign unused_bits = ^bus.trap_target_i[1:0];
`else
    assign bus.misalign_o      = 1'b0;
    assign bus.misalign_addr_o = '0;

    logic unused_bits;
    assign unused_bits = ^{bus.trap_target_i[1:0], apply_tgt[1:0], TRAP_VECTOR};
`endif

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed bench for pc_gen_unit with hand-computed expected PCs.
// Optional feature macro: PC_MISALIGN_TRAP_EN selects the misalign expectations.
module tb_pc_gen_unit;
  localparam int XLEN = 32;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;

  pc_gen_if #(.XLEN(XLEN)) bus ();

  pc_gen_unit #(
    .XLEN        (XLEN),
    .RESET_VECTOR(32'h8000_0000),
    .TRAP_VECTOR (32'h8000_0100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic stall, input logic br, input logic [XLEN-1:0] br_t,
                       input logic trap, input logic [XLEN-1:0] trap_t);
    bus.stall_i         = stall;
    bus.br_redirect_i   = br;
    bus.br_target_i     = br_t;
    bus.trap_redirect_i = trap;
    bus.trap_target_i   = trap_t;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pc(input string tag, input logic [XLEN-1:0] pc, input logic pend);
    check({tag, "_pc"}, bus.pc_o, pc);
    check({tag, "_pend"}, {31'd0, bus.pending_o}, {31'd0, pend});
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst    = 1'b1;
    idle();

    // reset then run
    tick(); check_pc("rst0", 32'h8000_0000, 1'b0);
    check("rst0_mis", {31'd0, bus.misalign_o}, 32'd0);
    check("rst0_maddr", bus.misalign_addr_o, 32'd0);
    tick(); check_pc("rst1", 32'h8000_0000, 1'b0);
    rst = 1'b0;
    tick(); check_pc("run1", 32'h8000_0004, 1'b0);
    tick(); check_pc("run2", 32'h8000_0008, 1'b0);
    tick(); check_pc("run3", 32'h8000_000C, 1'b0);
    check("run3_p4", bus.pc_plus4_o, 32'h8000_0010);
    tick(); check_pc("run4", 32'h8000_0010, 1'b0);

    // unstalled branch
    drive(1'b0, 1'b1, 32'h8000_0200, 1'b0, '0);
    tick(); check_pc("br", 32'h8000_0200, 1'b0);
    idle();
    tick(); check_pc("br_seq", 32'h8000_0204, 1'b0);

    // stalled branch, newer branch overwrites the latched target
    drive(1'b1, 1'b1, 32'h8000_0300, 1'b0, '0);
    tick(); check_pc("st1", 32'h8000_0204, 1'b1);
    drive(1'b1, 1'b1, 32'h8000_0400, 1'b0, '0);
    tick(); check_pc("st2", 32'h8000_0204, 1'b1);
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    tick(); check_pc("st3", 32'h8000_0204, 1'b1);
    idle();
    tick(); check_pc("st_rel", 32'h8000_0400, 1'b0);
    tick(); check_pc("st_seq", 32'h8000_0404, 1'b0);

    // trap overrides HOLD under stall; trap target low bits forced to zero
    drive(1'b1, 1'b1, 32'h8000_0500, 1'b0, '0);
    tick(); check_pc("hold", 32'h8000_0404, 1'b1);
    drive(1'b1, 1'b0, '0, 1'b1, 32'h8000_0103);
    tick(); check_pc("trap_hold", 32'h8000_0100, 1'b0);
    idle();
    tick(); check_pc("trap_seq", 32'h8000_0104, 1'b0);

    // simultaneous trap and branch in RUN
    drive(1'b0, 1'b1, 32'h8000_0700, 1'b1, 32'h8000_0600);
    tick(); check_pc("trap_br", 32'h8000_0600, 1'b0);
    idle();
    tick(); check_pc("trap_br_seq", 32'h8000_0604, 1'b0);

    // wrap
    drive(1'b0, 1'b0, '0, 1'b1, 32'hFFFF_FFFC);
    tick(); check_pc("wrap_pre", 32'hFFFF_FFFC, 1'b0);
    check("wrap_p4", bus.pc_plus4_o, 32'h0000_0000);
    idle();
    tick(); check_pc("wrap", 32'h0000_0000, 1'b0);

    // reset mid-HOLD discards the latched target
    drive(1'b1, 1'b1, 32'h8000_0800, 1'b0, '0);
    tick(); check_pc("rh_hold", 32'h0000_0000, 1'b1);
    rst = 1'b1;
    tick(); check_pc("rh_rst", 32'h8000_0000, 1'b0);
    rst = 1'b0;
    idle();
    tick(); check_pc("rh_run", 32'h8000_0004, 1'b0);

    // misaligned branch target, immediate
    drive(1'b0, 1'b1, 32'h8000_0202, 1'b0, '0);
    tick();
`ifdef PC_MISALIGN_TRAP_EN
    check_pc("mis", 32'h8000_0100, 1'b0);
    check("mis_pulse", {31'd0, bus.misalign_o}, 32'd1);
    check("mis_addr", bus.misalign_addr_o, 32'h8000_0202);
`else
    check_pc("mis", 32'h8000_0200, 1'b0);
    check("mis_pulse", {31'd0, bus.misalign_o}, 32'd0);
    check("mis_addr", bus.misalign_addr_o, 32'd0);
`endif
    idle();
    tick();
    check("mis_pulse_end", {31'd0, bus.misalign_o}, 32'd0);
`ifdef PC_MISALIGN_TRAP_EN
    check_pc("mis_seq", 32'h8000_0104, 1'b0);
    check("mis_addr_held", bus.misalign_addr_o, 32'h8000_0202);
`else
    check_pc("mis_seq", 32'h8000_0204, 1'b0);
`endif

    // misaligned target released from HOLD
    drive(1'b1, 1'b1, 32'h8000_0301, 1'b0, '0);
    tick();
    idle();
    tick();
`ifdef PC_MISALIGN_TRAP_EN
    check_pc("mis_hold", 32'h8000_0100, 1'b0);
    check("mis_hold_pulse", {31'd0, bus.misalign_o}, 32'd1);
    check("mis_hold_addr", bus.misalign_addr_o, 32'h8000_0301);
`else
    check_pc("mis_hold", 32'h8000_0300, 1'b0);
    check("mis_hold_pulse", {31'd0, bus.misalign_o}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
